codec_cfg_seq: RTL and testbench



---
 rtl/codec_cfg_pkg.sv | 52 +++++
 rtl/codec_cfg_rom.sv | 17 +
 rtl/codec_cfg_seq.sv | 172 +++++++++++++++++
 tb/tb_codec_cfg_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg
//   Shared definitions for the WM8731 configuration sequencer:
//   - FSM state enum
//   - WM8731 register addresses (7-bit)
//   - build_word(): packs a 7-bit address and 9-bit data into one control word
//   - INIT_TBL: the power-up control word sequence, sent in index order
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } cfg_state_e;

  // WM8731 register map
  localparam logic [6:0] R0_LLINE   = 7'h00;  // left line in
  localparam logic [6:0] R1_RLINE   = 7'h01;  // right line in
  localparam logic [6:0] R2_LHP     = 7'h02;  // left headphone out
  localparam logic [6:0] R3_RHP     = 7'h03;  // right headphone out
  localparam logic [6:0] R4_APATH   = 7'h04;  // analog audio path
  localparam logic [6:0] R5_DPATH   = 7'h05;  // digital audio path
  localparam logic [6:0] R6_PWR     = 7'h06;  // power down control
  localparam logic [6:0] R7_IFACE   = 7'h07;  // digital audio interface format
  localparam logic [6:0] R8_SRATE   = 7'h08;  // sampling control
  localparam logic [6:0] R9_ACTIVE  = 7'h09;  // active control
  localparam logic [6:0] R15_RESET  = 7'h0F;  // software reset

  function automatic logic [15:0] build_word(input logic [6:0] addr,
                                             input logic [8:0] data);
    return {addr, data};
  endfunction

  localparam int INIT_LEN = 11;

  localparam logic [15:0] INIT_TBL [INIT_LEN] = '{
    build_word(R15_RESET, 9'h000),  // 1E00 reset
    build_word(R6_PWR,    9'h000),  // 0C00 power all on
    build_word(R0_LLINE,  9'h017),  // 0017 line-in L
    build_word(R1_RLINE,  9'h017),  // 0217 line-in R
    build_word(R2_LHP,    9'h079),  // 0479 HP L
    build_word(R3_RHP,    9'h079),  // 0679 HP R
    build_word(R4_APATH,  9'h012),  // 0812 DAC select, mic muted
    build_word(R5_DPATH,  9'h000),  // 0A00 digital path
    build_word(R7_IFACE,  9'h001),  // 0E01 left-justified, 16-bit
    build_word(R8_SRATE,  9'h000),  // 1000 normal mode 48k
    build_word(R9_ACTIVE, 9'h001)   // 1201 active
  };

endpackage

// File: rtl/codec_cfg_rom.sv
// codec_cfg_rom
//   Combinational lookup of the init table.
//   i_idx  [3:0]  table index
//   o_word [15:0] control word; 16'h0000 for indices past the table end
module codec_cfg_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0]  i_idx,
  output logic [15:0] o_word
);

  always_comb begin
    o_word = 16'h0000;
    if (i_idx < 4'(INIT_LEN)) o_word = INIT_TBL[i_idx];
  end

endmodule

// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq
//   Walks the WM8731 init table, launching one I2C transfer per word,
//   retrying NACKed/timed-out words and reporting sticky done/error.
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     start           pulse: (re)run the sequence; ignored while busy
//     i2c_done        pulse from I2C controller: transfer finished
//     i2c_ack_ok      qualifies i2c_done: all bytes ACKed
//     i2c_go          pulse: launch one transfer
//     i2c_data        word being sent, held from go until done/timeout
//     word_idx        table index in flight
//     busy            run in progress
//     cfg_done        sticky: every word ACKed
//     cfg_err         sticky: a word ran out of retries
//     retry_cnt       resends of the current word so far
module codec_cfg_seq
  import codec_cfg_pkg::*;
#(
  parameter int NUM_WORDS   = 11,     // 1..16
  parameter int GAP_CYC     = 256,    // >= 1
  parameter int TIMEOUT_CYC = 65535,  // >= 1
  parameter int MAX_RETRY   = 3,      // 0..3
  parameter int AUTO_START  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        i2c_done,
  input  logic        i2c_ack_ok,
  output logic        i2c_go,
  output logic [15:0] i2c_data,
  output logic [3:0]  word_idx,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [1:0]  retry_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  // Counters load N-1 and act on reaching 0, so WAIT lasts TIMEOUT_CYC
  // cycles and GAP lasts exactly GAP_CYC cycles.
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYC - 1);
  localparam logic [3:0]       IDX_LAST  = 4'(NUM_WORDS - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  cfg_state_e       r_state, w_state_nxt;
  logic [15:0]      r_data;
  logic [3:0]       r_idx, w_idx_nxt;
  logic [1:0]       r_retry, w_retry_nxt;
  logic             r_busy, r_done, r_err;
  logic [TMO_W-1:0] r_tmo;
  logic [GAP_W-1:0] r_gcnt;
  logic             r_ok;    // result of the last transfer, acted on at end of GAP
  logic             r_auto;  // one-shot launch request armed by reset
  logic             w_launch, w_to_gap, w_gap_ok, w_set_done, w_set_err;
  logic [15:0]      w_rom_word;

  // Indexed by the next index so i2c_data is valid in the go cycle itself.
  codec_cfg_rom u_rom (
    .i_idx  (w_idx_nxt),
    .o_word (w_rom_word)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_retry_nxt = r_retry;
    w_launch    = 1'b0;
    w_to_gap    = 1'b0;
    w_gap_ok    = 1'b0;
    w_set_done  = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start || r_auto) begin
          w_launch    = 1'b1;
          w_idx_nxt   = '0;
          w_retry_nxt = '0;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // done takes priority over a simultaneous timeout expiry
        if (i2c_done) begin
          w_to_gap    = 1'b1;
          w_gap_ok    = i2c_ack_ok;
          w_state_nxt = ST_GAP;
        end else if (r_tmo == '0) begin
          w_to_gap    = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gcnt == '0) begin
          if (r_ok) begin
            if (r_idx == IDX_LAST) begin
              w_state_nxt = ST_DONE;
              w_set_done  = 1'b1;
            end else begin
              w_idx_nxt   = r_idx + 4'd1;
              w_retry_nxt = '0;
              w_state_nxt = ST_SEND;
            end
          end else if (r_retry < RETRY_MAX) begin
            w_retry_nxt = r_retry + 2'd1;
            w_state_nxt = ST_SEND;
          end else begin
            w_state_nxt = ST_ERROR;
            w_set_err   = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_data  <= 16'h0000;
      r_idx   <= '0;
      r_retry <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
      r_gcnt  <= '0;
      r_ok    <= 1'b0;
      r_auto  <= (AUTO_START != 0);
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_retry <= w_retry_nxt;
      if (w_state_nxt == ST_SEND) r_data <= w_rom_word;
      if (w_launch) begin
        r_auto <= 1'b0;
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_set_done) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_set_err) begin
        r_busy <= 1'b0;
        r_err  <= 1'b1;
      end
      // saturating countdown, never wraps
      if (r_state == ST_SEND)                    r_tmo <= TMO_LOAD;
      else if (r_state == ST_WAIT && r_tmo != '0) r_tmo <= r_tmo - 1'b1;
      if (w_to_gap) begin
        r_gcnt <= GAP_LOAD;
        r_ok   <= w_gap_ok;
      end else if (r_state == ST_GAP && r_gcnt != '0) begin
        r_gcnt <= r_gcnt - 1'b1;
      end
    end
  end

  assign i2c_go    = (r_state == ST_SEND);
  assign i2c_data  = r_data;
  assign word_idx  = r_idx;
  assign busy      = r_busy;
  assign cfg_done  = r_done;
  assign cfg_err   = r_err;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_codec_cfg_seq.sv
module tb_codec_cfg_seq;

  localparam int NW   = 11;
  localparam int GAP  = 20;
  localparam int TMO  = 100;
  localparam int MAXR = 3;
  localparam int BUDGET = 8000;

  localparam logic [15:0] TBL [NW] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217,
    16'h0479, 16'h0679, 16'h0812, 16'h0A00, 16'h0E01, 16'h1000, 16'h1201};

  localparam int M_ACK = 0, M_NACK4 = 1, M_NACK2 = 2, M_NORESP0 = 3,
                 M_EXPIRE = 4, M_HOLD5 = 5, M_RAND = 6;

  logic clk = 1'b0;
  logic reset, start, i2c_done, i2c_ack_ok;
  logic i2c_go, busy, cfg_done, cfg_err;
  logic [15:0] i2c_data;
  logic [3:0] word_idx;
  logic [1:0] retry_cnt;

  always #5 clk = ~clk;

  codec_cfg_seq #(.NUM_WORDS(NW), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO),
                  .MAX_RETRY(MAXR), .AUTO_START(1)) dut (
    .clk(clk), .reset(reset), .start(start), .i2c_done(i2c_done),
    .i2c_ack_ok(i2c_ack_ok), .i2c_go(i2c_go), .i2c_data(i2c_data),
    .word_idx(word_idx), .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .retry_cnt(retry_cnt));

  int n_cmp = 0, n_bad = 0;
  int mc = 0;          // cycle number; cycle c follows posedge c
  int mode = M_ACK;
  bit manual = 0;

  typedef struct { logic [15:0] data; int cyc; int retry; int idx; } go_rec_t;
  go_rec_t golog[$];

  // reference model state: what the outputs must be during cycle mc
  bit m_go, m_busy, m_done, m_err, m_auto, waiting, res_ok;
  logic [15:0] m_data;
  int m_idx, m_retry, go_at, res_at;

  function automatic logic [15:0] exp_word(int i);
    return (i < NW) ? TBL[i] : 16'h0000;
  endfunction

  function automatic int count_word(logic [15:0] w);
    int n = 0;
    foreach (golog[i]) if (golog[i].data == w) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), need %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Timeline model: a go launches at an absolute cycle, the transfer ends at
  // the first done inside the TMO cycles that follow it (or at the last of
  // them), and the next action happens GAP+1 cycles after that end.
  task automatic model_loop();
    forever begin
      @(posedge clk);
      mc++;
      m_go = 0;
      if (reset) begin
        m_busy = 0; m_done = 0; m_err = 0; m_idx = 0; m_retry = 0; m_data = 16'h0;
        m_auto = 1; waiting = 0; res_at = -1; go_at = -100;
      end else if (!m_busy) begin
        if (start || m_auto) begin
          m_auto = 0; m_done = 0; m_err = 0; m_idx = 0; m_retry = 0; m_busy = 1;
          m_go = 1; go_at = mc; m_data = exp_word(m_idx);
        end
      end else begin
        if (waiting) begin
          if (i2c_done) begin
            waiting = 0; res_ok = i2c_ack_ok; res_at = mc + GAP;
          end else if (mc - 1 == go_at + TMO) begin
            waiting = 0; res_ok = 0; res_at = mc + GAP;
          end
        end else if (mc == res_at) begin
          res_at = -1;
          if (res_ok && m_idx == NW - 1) begin
            m_busy = 0; m_done = 1;
          end else if (res_ok || m_retry < MAXR) begin
            if (res_ok) begin m_idx++; m_retry = 0; end
            else m_retry++;
            m_go = 1; go_at = mc; m_data = exp_word(m_idx);
          end else begin
            m_busy = 0; m_err = 1;
          end
        end
        if (go_at == mc - 1) waiting = 1;
      end
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (mc > 0) begin
        n_cmp++;
        if (i2c_go !== m_go || i2c_data !== m_data || word_idx !== 4'(m_idx) ||
            busy !== m_busy || cfg_done !== m_done || cfg_err !== m_err ||
            retry_cnt !== 2'(m_retry)) begin
          n_bad++;
          if (n_bad <= 30)
            $display("FAIL cycle%0d outputs: got go=%b data=%h idx=%0d busy=%b done=%b err=%b retry=%0d; need go=%b data=%h idx=%0d busy=%b done=%b err=%b retry=%0d",
                     mc, i2c_go, i2c_data, word_idx, busy, cfg_done, cfg_err, retry_cnt,
                     m_go, m_data, m_idx, m_busy, m_done, m_err, m_retry);
        end
      end
    end
  endtask

  // I2C controller stand-in: answers each go according to the current mode.
  task automatic responder();
    int resp_at = -1;
    bit resp_ack = 0;
    bit respond;
    int lat, r;
    forever begin
      @(posedge clk); #1;
      if (i2c_go) begin
        golog.push_back('{i2c_data, mc, int'(retry_cnt), int'(word_idx)});
        respond = 1; lat = 10; resp_ack = 1;
        case (mode)
          M_NACK4:   resp_ack = !(word_idx == 4 && retry_cnt == 0);
          M_NACK2:   resp_ack = (word_idx != 2);
          M_NORESP0: respond  = (word_idx != 0);
          M_EXPIRE:  if (word_idx == 0) lat = TMO;
          M_HOLD5:   respond  = (word_idx != 5);
          M_RAND: begin
            r = $urandom_range(0, 99);
            respond  = (r >= 5);
            lat      = $urandom_range(1, 12);
            resp_ack = (r >= 20);
          end
          default: ;
        endcase
        resp_at = respond ? mc + lat : -1;
      end
      if (!manual) begin
        i2c_done   = (mc == resp_at) || (mode == M_RAND && $urandom_range(0, 99) < 2);
        i2c_ack_ok = (mc == resp_at) ? resp_ack : 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic pulse_start();
    start = 1; @(negedge clk); start = 0;
  endtask

  task automatic run_wait(input string nm, input bit rand_start);
    int n = 0;
    do begin
      @(negedge clk); n++;
      if (rand_start) start = busy && ($urandom_range(0, 39) == 0);
    end while (!(!busy && (cfg_done || cfg_err)) && n < BUDGET);
    start = 0;
    if (n >= BUDGET) chk({nm, "_finish_in_budget"}, 0, 1);
  endtask

  initial begin
    int n;
    reset = 1; start = 0; i2c_done = 0; i2c_ack_ok = 0;
    fork model_loop(); compare_loop(); responder(); join_none

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_go", int'(i2c_go), 0);
    chk("rst_data", int'(i2c_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_flags", int'({cfg_done, cfg_err, retry_cnt, word_idx}), 0);

    // auto-start run, all ACKed; a start while busy must be ignored
    golog.delete();
    reset = 0;
    repeat (150) @(negedge clk);
    pulse_start();
    run_wait("s1", 0);
    chk("s1_sends", golog.size(), NW);
    for (int i = 0; i < NW; i++)
      chk($sformatf("s1_word%0d", i), (i < golog.size()) ? int'(golog[i].data) : -1, int'(TBL[i]));
    chk("s1_go_spacing", (golog.size() > 1) ? golog[1].cyc - golog[0].cyc : -1, 10 + GAP + 1);
    chk("s1_done", int'({cfg_done, cfg_err, busy}), 3'b100);

    // restart after done; word 4 NACKed once
    mode = M_NACK4;
    golog.delete();
    pulse_start();
    chk("s2_go_after_start", int'(i2c_go), 1);
    chk("s2_first_word", int'(i2c_data), 16'h1E00);
    chk("s2_done_cleared", int'(cfg_done), 0);
    run_wait("s2", 0);
    chk("s2_0479_sends", count_word(16'h0479), 2);
    n = -1;
    foreach (golog[i]) if (golog[i].data == 16'h0479) n = golog[i].retry;
    chk("s2_resend_retry", n, 1);
    chk("s2_sends", golog.size(), NW + 1);
    chk("s2_done", int'({cfg_done, cfg_err}), 2'b10);

    // word 2 always NACKed -> error
    mode = M_NACK2;
    golog.delete();
    pulse_start();
    run_wait("s3", 0);
    chk("s3_0017_sends", count_word(16'h0017), MAXR + 1);
    chk("s3_err", int'({cfg_done, cfg_err, busy}), 3'b010);
    chk("s3_idx", int'(word_idx), 2);
    repeat (200) @(negedge clk);
    chk("s3_no_more_go", golog.size(), 2 + MAXR + 1);

    // word 0 never answered -> timeouts
    mode = M_NORESP0;
    golog.delete();
    pulse_start();
    run_wait("s4", 0);
    chk("s4_sends", count_word(16'h1E00), MAXR + 1);
    for (int i = 1; i < 4; i++)
      chk($sformatf("s4_spacing%0d", i), (i < golog.size()) ? golog[i].cyc - golog[i-1].cyc : -1, TMO + GAP + 1);
    chk("s4_err", int'({cfg_err, word_idx}), 5'b10000);

    // done on the expiry cycle counts as success
    mode = M_EXPIRE;
    golog.delete();
    pulse_start();
    run_wait("s5", 0);
    chk("s5_1E00_once", count_word(16'h1E00), 1);
    chk("s5_spacing", (golog.size() > 1) ? golog[1].cyc - golog[0].cyc : -1, TMO + GAP + 1);
    chk("s5_done", int'({cfg_done, cfg_err}), 2'b10);

    // reset mid-WAIT on word 5, then a late done
    mode = M_HOLD5;
    pulse_start();
    n = 0;
    while (!(i2c_go && word_idx == 5) && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) chk("s6_reach_word5", 0, 1);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    golog.delete();
    manual = 1; i2c_done = 1; i2c_ack_ok = 1;
    chk("s6_rst_outputs", int'({i2c_go, busy, cfg_done, cfg_err, retry_cnt, word_idx}), 0);
    chk("s6_rst_data", int'(i2c_data), 0);
    @(negedge clk);
    manual = 0; i2c_done = 0; i2c_ack_ok = 0;
    mode = M_ACK;
    chk("s6_auto_go", int'({i2c_go, i2c_data}), {1'b1, 16'h1E00});
    run_wait("s6", 0);
    chk("s6_sends", golog.size(), NW);
    chk("s6_done", int'({cfg_done, cfg_err}), 2'b10);

    // randomized latencies, NACKs, timeouts, stray dones, starts while busy
    for (int r = 0; r < 4; r++) begin
      mode = M_RAND;
      pulse_start();
      run_wait($sformatf("rand%0d", r), 1);
      chk($sformatf("rand%0d_one_flag", r), int'(cfg_done ^ cfg_err), 1);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
